// File: rtl/cpu_fetch_queue_if.sv
// Fetch-queue bus: memory request/response channel plus the decoder-side head and redirect.
// master = fetch queue, slave = memory/decoder environment.
interface cpu_fetch_queue_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);
  logic [ADDR_W-1:0]  iaddr;
  logic               ireq;
  logic               igrant;
  logic               irvalid;
  logic [INSTR_W-1:0] idata;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;

  modport master (
    output iaddr, ireq, instr, instr_pc, instr_valid,
    input  igrant, irvalid, idata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  iaddr, ireq, instr, instr_pc, instr_valid,
    output igrant, irvalid, idata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/cpu_fetch_queue.sv
// Instruction fetch front end: credit-limited PC sequencer, in-order response queue, redirect flush/drop.
// Response->instr_valid 1 cycle (0 with FETCH_BYPASS_EN); ireq withheld when outstanding+count reaches DEPTH.
module cpu_fetch_queue #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INSTR_W  = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  cpu_fetch_queue_if.master        fq,
  output logic [ADDR_W-1:0]        PC,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              run_q, run_d;
  entry_t            fifo_q [DEPTH];
  entry_t            fifo_d [DEPTH];

  logic [CNT_W:0]    credit_sum;
  logic              credit_ok;
  logic              issue;
  logic              resp_acc;
  logic              resp_keep;
  logic              bypass;
  logic              push;
  logic              q_pop;
  logic [ADDR_W-1:0] target_pc;
  entry_t            head;

  // run_q keeps ireq low during reset and for the first cycle after release
  always_comb begin
    credit_sum = {1'b0, outst_q} + {1'b0, count_q};
    credit_ok  = credit_sum < (CNT_W+1)'(DEPTH);
    fq.ireq    = run_q && credit_ok && !fq.redirect;
    issue      = fq.ireq && fq.igrant;
    resp_acc   = fq.irvalid && (outst_q != '0);
    resp_keep  = resp_acc && (drop_q == '0) && !fq.redirect;
    q_pop      = (count_q != '0) && fq.instr_ready;
    target_pc  = {fq.redirect_pc[ADDR_W-1:2], 2'b00};
    head       = fifo_q[rd_ptr_q];
`ifdef FETCH_BYPASS_EN
    bypass     = resp_keep && (count_q == '0);
`else
    bypass     = 1'b0;
`endif
    push       = resp_keep && !(bypass && fq.instr_ready);
  end

  always_comb begin
    fq.iaddr       = pc_q;
    PC             = pc_q;
    count          = count_q;
    fq.instr_valid = (count_q != '0) || bypass;
    fq.instr       = bypass ? fq.idata   : head.instr;
    fq.instr_pc    = bypass ? resp_pc_q  : head.pc;
  end

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    outst_d   = outst_q + CNT_W'(issue) - CNT_W'(resp_acc);
    drop_d    = drop_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(q_pop);
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    run_d     = 1'b1;
    fifo_d    = fifo_q;

    if (issue) begin
      pc_d = pc_q + PC_STEP;
    end
    if (resp_keep) begin
      resp_pc_d = resp_pc_q + PC_STEP;
    end
    if (resp_acc && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end
    if (push) begin
      fifo_d[wr_ptr_q] = '{instr: fq.idata, pc: resp_pc_q};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (q_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Redirect wins: same-cycle pop has already been handed out, everything in flight becomes stale
    if (fq.redirect) begin
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      pc_d      = target_pc;
      resp_pc_d = target_pc;
      drop_d    = outst_q - CNT_W'(resp_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      run_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      run_q     <= run_d;
      fifo_q    <= fifo_d;
    end
  end

endmodule
